// File: rtl/alu_ror_pkg.sv
// Shared widths, FSM state type and amount reduction for the rotate-right arbiter.
package alu_ror_pkg;

  localparam int unsigned DATA_W = 7;
  localparam int unsigned AMT_W  = 4;
  localparam int unsigned EFF_W  = 3;

  typedef enum logic {IDLE, BUSY} state_e;

  // 0..15 -> 0..6; two conditional subtractions cover the whole 4-bit range
  function automatic logic [EFF_W-1:0] mod7(input logic [AMT_W-1:0] amt);
    logic [AMT_W-1:0] r;
    if (amt >= AMT_W'(14))     r = amt - AMT_W'(14);
    else if (amt >= AMT_W'(7)) r = amt - AMT_W'(7);
    else                       r = amt;
    return r[EFF_W-1:0];
  endfunction

endpackage

// File: rtl/ror7_core.sv
// Combinational 7-bit rotate-right; amounts 0..6 rotate, 7 passes the operand through.
module ror7_core
  import alu_ror_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [EFF_W-1:0]  amt_i,
  output logic [DATA_W-1:0] data_o
);

  // Shifting the doubled operand wraps the low bits into the top; amount 7 lands on the copy
  always_comb begin
    data_o = DATA_W'({data_i, data_i} >> amt_i);
  end

endmodule

// File: rtl/alu_ror_arbiter.sv
// Round-robin arbiter sharing one ror7_core between two requesters, with a registered result.
// Optional per-requester result counters are enabled by defining ROR_ARB_CNT_EN.
module alu_ror_arbiter
  import alu_ror_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [AMT_W-1:0]  req0_amt,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [AMT_W-1:0]  req1_amt,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_id
`ifdef ROR_ARB_CNT_EN
  ,
  output logic [7:0]        cnt0,
  output logic [7:0]        cnt1
`endif
);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_id_q, res_id_d;

  logic              gnt0, gnt1, can_accept, accept;
  logic [DATA_W-1:0] sel_data, rot_data;
  logic [EFF_W-1:0]  eff;

  always_comb begin
    gnt0       = req0_valid && (!req1_valid || last_q);
    gnt1       = req1_valid && (!req0_valid || !last_q);
    // With only two states this is IDLE || (BUSY && res_ready)
    can_accept = (state_q == IDLE) || res_ready;
    accept     = (gnt0 || gnt1) && can_accept;
    req0_ready = gnt0 && can_accept;
    req1_ready = gnt1 && can_accept;
    sel_data   = gnt1 ? req1_data : req0_data;
    eff        = mod7(gnt1 ? req1_amt : req0_amt);
  end

  ror7_core u_ror7_core (
    .data_i (sel_data),
    .amt_i  (eff),
    .data_o (rot_data)
  );

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    res_data_d = res_data_q;
    res_id_d   = res_id_q;
    case (state_q)
      IDLE: if (accept) state_d = BUSY;
      BUSY: if (res_ready && !accept) state_d = IDLE;
    endcase
    if (accept) begin
      res_data_d = rot_data;
      res_id_d   = gnt1;
      last_d     = gnt1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      res_data_q <= '0;
      res_id_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      res_data_q <= res_data_d;
      res_id_q   <= res_id_d;
    end
  end

  assign res_valid = (state_q == BUSY);
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;

`ifdef ROR_ARB_CNT_EN
  logic [7:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (res_valid && res_ready) begin
      if (res_id_q) cnt1_q <= cnt1_q + 8'd1;
      else          cnt0_q <= cnt0_q + 8'd1;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_ror_arbiter.sv
// Self-checking bench for alu_ror_arbiter; counter checks compile in with ROR_ARB_CNT_EN.
module tb_alu_ror_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [6:0] req0_data, req1_data;
  logic [3:0] req0_amt, req1_amt;
  logic       res_valid, res_ready, res_id;
  logic [6:0] res_data;
`ifdef ROR_ARB_CNT_EN
  logic [7:0] cnt0, cnt1;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic       m_valid, m_id, m_last;
  logic [6:0] m_data;
  int         m_cnt0, m_cnt1;

  alu_ror_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_amt   (req0_amt),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_amt   (req1_amt),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_id     (res_id)
`ifdef ROR_ARB_CNT_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_ror(input logic [6:0] d, input logic [3:0] amt);
    int k, x;
    k = int'(amt) % 7;
    x = int'(d);
    x = (x >> k) | (x << (7 - k));
    return 7'(x & 127);
  endfunction

  function automatic int exp_gnt();
    if (req0_valid && req1_valid) return m_last ? 0 : 1;
    if (req1_valid) return 1;
    return 0;
  endfunction

  function automatic logic exp_rdy(input int n);
    logic v;
    v = (n == 0) ? req0_valid : req1_valid;
    return v && (exp_gnt() == n) && (!m_valid || res_ready);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_id = 1'b0; m_last = 1'b1; m_data = '0;
    m_cnt0 = 0; m_cnt1 = 0;
  endtask

  task automatic drive(input logic v0, input logic [6:0] d0, input logic [3:0] a0,
                       input logic v1, input logic [6:0] d1, input logic [3:0] a1,
                       input logic rr);
    req0_valid = v0; req0_data = d0; req0_amt = a0;
    req1_valid = v1; req1_data = d1; req1_amt = a1;
    res_ready  = rr;
    #1;
  endtask

  // Advance one clock edge and move the model along with it
  task automatic tick();
    int g;
    bit acc, hs;
    g   = exp_gnt();
    acc = (req0_valid || req1_valid) && (!m_valid || res_ready);
    hs  = m_valid && res_ready;
    @(posedge clk);
    if (hs) begin
      if (m_id) m_cnt1 = (m_cnt1 + 1) % 256;
      else      m_cnt0 = (m_cnt0 + 1) % 256;
    end
    if (acc) begin
      m_valid = 1'b1;
      m_id    = g[0];
      m_last  = g[0];
      m_data  = (g == 1) ? ref_ror(req1_data, req1_amt) : ref_ror(req0_data, req0_amt);
    end else if (hs) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    drive(0, '0, '0, 0, '0, '0, 0);
    #12;
    n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", res_valid); end
    n_chk++; if (res_data !== 7'd0) begin n_fail++; $display("FAIL reset_data: got %b expected 0000000", res_data); end
    n_chk++; if (res_id !== 1'b0) begin n_fail++; $display("FAIL reset_id: got %b expected 0", res_id); end
    n_chk++; if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready}); end
`ifdef ROR_ARB_CNT_EN
    n_chk++; if ({cnt0, cnt1} !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %h/%h expected 00/00", cnt0, cnt1); end
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    drive(1, 7'b1000001, 4'd1, 0, '0, '0, 1);
    n_chk++; if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL basic_ready0: got %b expected 10", {req0_ready, req1_ready}); end
    tick();
    n_chk++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid0: got %b expected 1", res_valid); end
    n_chk++; if (res_data !== 7'b1100000) begin n_fail++; $display("FAIL basic_data0: got %b expected 1100000", res_data); end
    n_chk++; if (res_id !== 1'b0) begin n_fail++; $display("FAIL basic_id0: got %b expected 0", res_id); end
    drive(0, '0, '0, 1, 7'b1000001, 4'd9, 1);
    n_chk++; if ({req0_ready, req1_ready} !== 2'b01) begin n_fail++; $display("FAIL basic_ready1: got %b expected 01", {req0_ready, req1_ready}); end
    tick();
    n_chk++; if (res_data !== 7'b0110000) begin n_fail++; $display("FAIL basic_data1: got %b expected 0110000", res_data); end
    n_chk++; if (res_id !== 1'b1) begin n_fail++; $display("FAIL basic_id1: got %b expected 1", res_id); end
    drive(0, '0, '0, 0, '0, '0, 1);
    tick();
    n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %b expected 0", res_valid); end
  endtask

  task automatic test_mod7();
    drive(1, 7'b1011001, 4'd7, 0, '0, '0, 1);
    tick();
    n_chk++; if (res_data !== 7'b1011001) begin n_fail++; $display("FAIL mod7_amt7: got %b expected 1011001", res_data); end
    drive(0, '0, '0, 1, 7'b1011001, 4'd14, 1);
    tick();
    n_chk++; if (res_data !== 7'b1011001) begin n_fail++; $display("FAIL mod7_amt14: got %b expected 1011001", res_data); end
    n_chk++; if (res_id !== 1'b1) begin n_fail++; $display("FAIL mod7_id: got %b expected 1", res_id); end
    drive(0, '0, '0, 0, '0, '0, 1);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [6:0] hd;
    logic       hid;
    for (int i = 0; i < 4; i++) begin
      drive(1, 7'($urandom), 4'($urandom), 1, 7'($urandom), 4'($urandom), 1);
      tick();
      n_chk++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, res_valid); end
      n_chk++; if (res_id !== 1'(i % 2)) begin n_fail++; $display("FAIL b2b_id[%0d]: got %b expected %0d", i, res_id, i % 2); end
      n_chk++; if (res_data !== m_data) begin n_fail++; $display("FAIL b2b_data[%0d]: got %b expected %b", i, res_data, m_data); end
    end
    hd  = m_data;
    hid = m_id;
    for (int i = 0; i < 3; i++) begin
      drive(1, 7'($urandom), 4'($urandom), 1, 7'($urandom), 4'($urandom), 0);
      n_chk++; if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL hold_ready[%0d]: got %b expected 00", i, {req0_ready, req1_ready}); end
      tick();
      n_chk++; if ({res_valid, res_id, res_data} !== {1'b1, hid, hd}) begin n_fail++; $display("FAIL hold_result[%0d]: got %b/%b/%b expected 1/%b/%b", i, res_valid, res_id, res_data, hid, hd); end
    end
    drive(0, '0, '0, 0, '0, '0, 1);
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 7'($urandom), 4'($urandom), 1'($urandom), 7'($urandom), 4'($urandom),
            ($urandom_range(0, 3) != 0));
      n_chk++; if ({req0_ready, req1_ready} !== {exp_rdy(0), exp_rdy(1)}) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", i, {req0_ready, req1_ready}, {exp_rdy(0), exp_rdy(1)}); end
      tick();
      n_chk++; if ({res_valid, res_id, res_data} !== {m_valid, m_id, m_data}) begin n_fail++; $display("FAIL rand_result[%0d]: got %b/%b/%b expected %b/%b/%b", i, res_valid, res_id, res_data, m_valid, m_id, m_data); end
`ifdef ROR_ARB_CNT_EN
      n_chk++; if ({cnt0, cnt1} !== {8'(m_cnt0), 8'(m_cnt1)}) begin n_fail++; $display("FAIL rand_cnt[%0d]: got %0d/%0d expected %0d/%0d", i, cnt0, cnt1, m_cnt0, m_cnt1); end
`endif
    end
    drive(0, '0, '0, 0, '0, '0, 1);
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1, 7'b0101101, 4'd3, 0, '0, '0, 0);
    tick();
    n_chk++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 1", res_valid); end
    drive(0, '0, '0, 1, 7'b1110000, 4'd2, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_drop: got %b expected 0", res_valid); end
    n_chk++; if (res_data !== 7'd0) begin n_fail++; $display("FAIL rstmid_data: got %b expected 0000000", res_data); end
    drive(1, 7'b0000011, 4'd1, 1, 7'b1110000, 4'd2, 1);
    @(posedge clk); #1;
    n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_held: got %b expected 0", res_valid); end
    rst_n = 1'b1;
    #1;
    n_chk++; if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL rstmid_tie: got %b expected 10", {req0_ready, req1_ready}); end
    tick();
    n_chk++; if ({res_valid, res_id, res_data} !== {1'b1, 1'b0, 7'b1000001}) begin n_fail++; $display("FAIL rstmid_first: got %b/%b/%b expected 1/0/1000001", res_valid, res_id, res_data); end
    drive(0, '0, '0, 0, '0, '0, 1);
    tick();
  endtask

`ifdef ROR_ARB_CNT_EN
  task automatic test_counters();
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      drive(1, 7'($urandom), 4'($urandom), 0, '0, '0, 1);
      tick();
    end
    drive(0, '0, '0, 0, '0, '0, 1);
    tick();
    n_chk++; if (cnt0 !== 8'd0) begin n_fail++; $display("FAIL cnt_wrap0: got %0d expected 0", cnt0); end
    n_chk++; if (cnt1 !== 8'd0) begin n_fail++; $display("FAIL cnt_wrap1: got %0d expected 0", cnt1); end
    drive(1, 7'($urandom), 4'($urandom), 0, '0, '0, 1);
    tick();
    drive(0, '0, '0, 0, '0, '0, 1);
    tick();
    n_chk++; if (cnt0 !== 8'd1) begin n_fail++; $display("FAIL cnt_after: got %0d expected 1", cnt0); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_mod7();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef ROR_ARB_CNT_EN
    test_counters();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
